// File: rtl/keypad_emulator.sv
// Far end of a 3x4 scanned keypad: takes key codes over a request handshake and
// pulls the matching row low whenever the scanner strobes that key's column.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES = 200000,
  parameter int unsigned GAP_CYCLES  = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col,
  output logic [3:0] row,
  input  logic [3:0] key_code,
  input  logic       key_req,
  output logic       key_ready,
  input  logic       key_abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] col_idx;
    logic [1:0] row_idx;
  } key_pos_t;

  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [23:0] cnt_q;
  logic [3:0]  code_q;
  logic        done_q;
  logic        err_q;

  key_pos_t    req_pos;
  key_pos_t    lat_pos;
  logic        col_hit;

  // Matrix position of each code; 12..15 have no key.
  function automatic key_pos_t decode(input logic [3:0] code);
    key_pos_t p;
    p = '{valid: 1'b1, col_idx: 2'd0, row_idx: 2'd0};
    case (code)
      4'd1:    begin p.col_idx = 2'd0; p.row_idx = 2'd0; end
      4'd4:    begin p.col_idx = 2'd0; p.row_idx = 2'd1; end
      4'd7:    begin p.col_idx = 2'd0; p.row_idx = 2'd2; end
      4'd0:    begin p.col_idx = 2'd0; p.row_idx = 2'd3; end
      4'd2:    begin p.col_idx = 2'd1; p.row_idx = 2'd0; end
      4'd5:    begin p.col_idx = 2'd1; p.row_idx = 2'd1; end
      4'd8:    begin p.col_idx = 2'd1; p.row_idx = 2'd2; end
      4'd10:   begin p.col_idx = 2'd1; p.row_idx = 2'd3; end
      4'd3:    begin p.col_idx = 2'd2; p.row_idx = 2'd0; end
      4'd6:    begin p.col_idx = 2'd2; p.row_idx = 2'd1; end
      4'd9:    begin p.col_idx = 2'd2; p.row_idx = 2'd2; end
      4'd11:   begin p.col_idx = 2'd2; p.row_idx = 2'd3; end
      default: p.valid = 1'b0;
    endcase
    return p;
  endfunction

  assign req_pos = decode(key_code);
  assign lat_pos = decode(code_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_req) begin
            if (req_pos.valid) begin
              code_q  <= key_code;
              cnt_q   <= '0;
              state_q <= PRESS;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        PRESS: begin
          if (key_abort || cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The row follows the column strobe combinationally, as a closed switch would.
  always_comb begin
    col_hit = 1'b0;
    case (lat_pos.col_idx)
      2'd0:    col_hit = ~col[0];
      2'd1:    col_hit = ~col[1];
      2'd2:    col_hit = ~col[2];
      default: col_hit = 1'b0;
    endcase
    row = 4'b1111;
    if (state_q == PRESS && col_hit) begin
      row[lat_pos.row_idx] = 1'b0;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q == PRESS) || (state_q == RELEASE);
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator with short hold/gap: directed presses, abort, reset,
// chained requests and random presses, with done/err events scored from a queue.
module tb_keypad_emulator;

  localparam int H = 8;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_req;
  logic       key_ready;
  logic       key_abort;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [3:0]  acc_code = 4'd0;
  // Entry: {is_err, code, cycles from accept-request cycle to event}
  logic [15:0] exp_q[$];

  keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_req   (key_req),
    .key_ready (key_ready),
    .key_abort (key_abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset helpers ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference keypad map
  function automatic logic [3:0] model_row(input logic [3:0] code, input logic [2:0] c);
    int kc;
    int kr;
    logic [3:0] r;
    kc = -1;
    kr = 0;
    case (code)
      4'd1:  begin kc = 0; kr = 0; end
      4'd4:  begin kc = 0; kr = 1; end
      4'd7:  begin kc = 0; kr = 2; end
      4'd0:  begin kc = 0; kr = 3; end
      4'd2:  begin kc = 1; kr = 0; end
      4'd5:  begin kc = 1; kr = 1; end
      4'd8:  begin kc = 1; kr = 2; end
      4'd10: begin kc = 1; kr = 3; end
      4'd3:  begin kc = 2; kr = 0; end
      4'd6:  begin kc = 2; kr = 1; end
      4'd9:  begin kc = 2; kr = 2; end
      4'd11: begin kc = 2; kr = 3; end
      default: kc = -1;
    endcase
    r = 4'b1111;
    if (kc >= 0 && c[kc] == 1'b0) r[kr] = 1'b0;
    return r;
  endfunction

  function automatic logic [2:0] col_for(input int mode, input int i);
    if (mode == 0) begin
      case (i % 3)
        0:       return 3'b110;
        1:       return 3'b101;
        default: return 3'b011;
      endcase
    end else if (mode == 1) begin
      return 3'b110;
    end
    return 3'($urandom_range(0, 7));
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset && (done || err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {14'd0, done, err}, 16'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("event", {err, acc_code, 11'(cyc - acc_cyc)}, e);
      end
    end
    if (!reset && key_req && key_ready) begin
      acc_cyc  = cyc;
      acc_code = key_code;
    end
  end

  // ---------------- driver ----------------
  task automatic do_press(input logic [3:0] code, input int abort_at, input int mode,
                          input logic chain, input logic [3:0] next_code);
    int guard;
    int plen;
    logic valid;
    guard = 0;
    valid = (code <= 4'd11);
    key_code = code;
    key_req  = 1'b1;
    while (!key_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!key_ready) begin
      check_eq("ready_timeout", 16'd0, 16'd1);
      key_req = 1'b0;
      return;
    end
    plen = (abort_at >= 0 && abort_at < H) ? abort_at + 1 : H;
    if (!valid) exp_q.push_back({1'b1, code, 11'd1});
    else        exp_q.push_back({1'b0, code, 11'(plen + G + 1)});
    step();
    key_req = chain;
    if (chain) key_code = next_code;
    if (!valid) begin
      @(negedge clk);
      check_eq("rej_row", {12'd0, row}, 16'h000f);
      check_eq("rej_busy_ready", {14'd0, busy, key_ready}, 16'd1);
      step();
      return;
    end
    for (int i = 0; i < plen + G; i++) begin
      col = col_for(mode, i);
      key_abort = (i == abort_at);
      @(negedge clk);
      check_eq("row", {12'd0, row}, {12'd0, (i < plen) ? model_row(code, col) : 4'b1111});
      check_eq("busy_ready", {14'd0, busy, key_ready}, 16'd2);
      step();
    end
    key_abort = 1'b0;
    @(negedge clk);
    check_eq("done_cycle_ready", {14'd0, busy, key_ready}, 16'd1);
    if (!chain) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    reset = 1'b1; key_req = 1'b0; key_abort = 1'b0; key_code = 4'd0; col = 3'b111;
    step();
    step();
    @(negedge clk);
    check_eq("rst_row", {12'd0, row}, 16'h000f);
    check_eq("rst_busy_ready", {14'd0, busy, key_ready}, 16'd1);
    check_eq("rst_done_err", {14'd0, done, err}, 16'd0);
    check_eq("rst_state", {14'd0, dbg_state}, 16'd0);
    step();
    reset = 1'b0;
    step();

    do_press(4'd5, -1, 0, 1'b0, 4'd0);
    do_press(4'd13, -1, 0, 1'b0, 4'd0);
    do_press(4'd15, -1, 2, 1'b0, 4'd0);
    do_press(4'd11, 3, 0, 1'b0, 4'd0);
    do_press(4'd2, H + 1, 2, 1'b0, 4'd0);
    do_press(4'd8, 0, 1, 1'b0, 4'd0);
    do_press(4'd4, H - 1, 1, 1'b0, 4'd0);

    // Reset during PRESS cycle 5 of code 1
    key_code = 4'd1;
    key_req  = 1'b1;
    guard = 0;
    while (!key_ready && guard < 50) begin step(); guard++; end
    step();
    key_req = 1'b0;
    col = 3'b110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("pre_rst_row", {12'd0, row}, 16'h000e);
      step();
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_cycle_row", {12'd0, row}, 16'h000e);
    step();
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_row", {12'd0, row}, 16'h000f);
    check_eq("post_rst_busy_ready", {14'd0, busy, key_ready}, 16'd1);
    check_eq("post_rst_done", {15'd0, done}, 16'd0);
    step();
    repeat (15) step();

    // Request held across busy: 0 then 7
    do_press(4'd0, -1, 1, 1'b1, 4'd7);
    do_press(4'd7, -1, 1, 1'b0, 4'd0);

    repeat (12) begin
      do_press(4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, H + G - 1)) : -1,
               2, 1'b0, 4'd0);
    end

    repeat (20) step();
    check_eq("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Purpose: electrical far end of the 3-column x 4-row scanned keypad. It accepts key codes over a request handshake (remote/app injection, test) and drives the row lines exactly as a physically pressed matrix key would, for a timed hold and release gap.

Interface
REQ-001 The module SHALL have a parameter HOLD_CYCLES, default 200000, giving press duration in clk cycles; legal range 1..2^24-1, and it must exceed the scanner debounce of 100000.
REQ-002 The module SHALL have a parameter GAP_CYCLES, default 50000, giving the released gap in clk cycles after each press; legal range 1..2^24-1.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port col, input, 3 bits: column strobes from the scanner, active-low.
REQ-006 The module SHALL have port row, output, 4 bits: row lines back to the scanner, active-low, 4'b1111 when idle.
REQ-007 The module SHALL have port key_code, input, 4 bits: key to press.
REQ-008 The module SHALL have port key_req, input, 1 bit: request to press key_code.
REQ-009 The module SHALL have port key_ready, output, 1 bit: high when a request can be accepted.
REQ-010 The module SHALL have port key_abort, input, 1 bit: ends an active press early.
REQ-011 The module SHALL have port busy, output, 1 bit: high in PRESS or RELEASE.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse when a press sequence completes.
REQ-013 The module SHALL have port err, output, 1 bit: one-cycle pulse when an invalid code is rejected.

Function
REQ-014 Key map as (column, row bit): 1 is (0,0), 4 is (0,1), 7 is (0,2), 0 is (0,3); 2 is (1,0), 5 is (1,1), 8 is (1,2), 10 is (1,3) for *; 3 is (2,0), 6 is (2,1), 9 is (2,2), 11 is (2,3) for #. Codes 12..15 SHALL be invalid.
REQ-015 The FSM SHALL have states IDLE, PRESS and RELEASE. key_ready SHALL be 1 exactly in IDLE, and busy SHALL be 1 exactly in PRESS or RELEASE.
REQ-016 Accept: key_req=1 and key_ready=1 at an edge SHALL latch key_code and enter PRESS with the counter cleared. A valid code SHALL be latched and entered in the same edge.
REQ-017 An invalid code at accept SHALL pulse err for 1 cycle starting the next cycle, keep the FSM in IDLE, and leave row at 4'b1111.
REQ-018 key_req while busy SHALL be ignored. The requester must hold key_req until it sees key_ready.
REQ-019 In PRESS, row SHALL be combinational from col and state: row[r]=0 only if r is the latched row and col[c]=0 for the latched column c. All other row bits SHALL be 1. When several columns are low, the target row is driven low if its column is among them.
REQ-020 Outside PRESS, row SHALL be 4'b1111 regardless of col.
REQ-021 PRESS SHALL last exactly HOLD_CYCLES cycles, with the counter running 0..HOLD_CYCLES-1, and then enter RELEASE with the counter cleared.
REQ-022 RELEASE SHALL last exactly GAP_CYCLES cycles, then enter IDLE and pulse done for 1 cycle, coincident with the first IDLE cycle.
REQ-023 key_abort=1 in PRESS SHALL enter RELEASE at the next edge, and the full GAP_CYCLES gap and the done pulse SHALL still follow. key_abort SHALL be ignored in IDLE and RELEASE.
REQ-024 Counter width SHALL be 24 bits, with no wrap within legal parameter ranges.
REQ-025 Back-to-back operation: a new request may be accepted on the done cycle. The press sequences SHALL keep a minimum spacing of HOLD_CYCLES+GAP_CYCLES cycles.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, clear the counter and latched code, and set done=0 and err=0. After that edge, row SHALL be 4'b1111, key_ready=1 and busy=0.
REQ-027 Reset SHALL take priority over key_req and key_abort in the same cycle.
REQ-028 Reset mid-PRESS SHALL release row on the same edge, with no done pulse.

Verification (HOLD_CYCLES=8, GAP_CYCLES=4 unless stated)
REQ-029 Press code 5 with col cycling 110,101,011: row=1101 only while col=101 for 8 cycles, then 1111; done 4 cycles after PRESS exits; key_ready high at the done cycle.
REQ-030 key_code=13 with key_req: err pulses once, row stays 1111, key_ready stays 1, busy stays 0.
REQ-031 Press code 11, assert key_abort at PRESS cycle 3: row goes 1111 at the next edge; done follows 4 cycles later.
REQ-032 Reset asserted at PRESS cycle 5 of code 1 with col=110: row goes 1111 after that edge; no done; key_ready=1.
REQ-033 Hold key_req with code 0, then 7, across busy: exactly two presses, with row 0111 then 1011 on col=110, separated by a 4-cycle gap.
REQ-034 Defaults against the live keypad scanner at default debounce, press code 9: scanner reports key_valid with key_value 9; no false key during the 50000-cycle gap.
